// File: rtl/int_ctrl.sv
// Interrupt/entry-point controller: issues the boot redirect, then masks, prioritises and dispatches requests.
// Define IRQ_EDGE_EN for edge-triggered request latching; the default build is level mode.
module int_ctrl #(
    parameter int          NIRQ       = 4,
    parameter logic [31:0] VEC_STRIDE = 32'h10,
    parameter logic [31:0] BOOT_ADDR  = 32'h28
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NIRQ-1:0]           irq_i,
    input  logic                      mask_we_i,
    input  logic [NIRQ-1:0]           mask_wd_i,
    input  logic                      iret_i,
    input  logic [31:0]               vec_base_i,
    output logic                      INT_o,
    output logic [31:0]               entryPoint_o,
    output logic                      busy_o,
    output logic [((NIRQ > 1) ? $clog2(NIRQ) : 1)-1:0] cause_o,
    output logic [NIRQ-1:0]           mask_o,
    output logic [NIRQ-1:0]           pending_o
);

    localparam int CW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

    typedef enum logic [1:0] {
        BOOT,
        IDLE,
        FIRE,
        SERVICE
    } state_e;

    state_e            state_q, state_d;
    logic              int_q, int_d;
    logic [31:0]       entry_q, entry_d;
    logic              busy_q, busy_d;
    logic [CW-1:0]     cause_q, cause_d;
    logic [NIRQ-1:0]   mask_q, mask_d;
    logic [NIRQ-1:0]   pending_q, pending_d;

    logic [NIRQ-1:0]   active;
    logic              anyReq;
    logic [CW-1:0]     selIdx;
    logic              dispatch;

    assign active = pending_q & mask_q;
    assign anyReq = |active;

    // Lowest set index wins; scanning downward leaves the smallest index last.
    always_comb begin
        selIdx = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                selIdx = CW'(i);
            end
        end
    end

    // Holding off while INT is still high keeps strobes from landing back to back after boot.
    assign dispatch = (state_q == IDLE) && !int_q && anyReq;

    always_comb begin
        state_d = state_q;
        int_d   = 1'b0;
        entry_d = entry_q;
        busy_d  = busy_q;
        cause_d = cause_q;
        case (state_q)
            BOOT: begin
                int_d   = 1'b1;
                entry_d = BOOT_ADDR;
                state_d = IDLE;
            end
            IDLE: begin
                if (dispatch) begin
                    int_d   = 1'b1;
                    cause_d = selIdx;
                    entry_d = vec_base_i + 32'(selIdx) * VEC_STRIDE;
                    state_d = FIRE;
                end
            end
            FIRE: begin
                busy_d  = 1'b1;
                state_d = SERVICE;
            end
            SERVICE: begin
                if (iret_i) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    assign mask_d = mask_we_i ? mask_wd_i : mask_q;

`ifdef IRQ_EDGE_EN
    logic [NIRQ-1:0] irqPrev_q;
    logic [NIRQ-1:0] clearMask;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irqPrev_q <= '0;
        end else begin
            irqPrev_q <= irq_i;
        end
    end

    // A new rising edge is OR-ed in after the clear, so set beats dispatch-clear.
    assign clearMask = dispatch ? (NIRQ'(1) << selIdx) : '0;
    assign pending_d = (pending_q & ~clearMask) | (irq_i & ~irqPrev_q);
`else
    assign pending_d = irq_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= BOOT;
            int_q     <= 1'b0;
            entry_q   <= BOOT_ADDR;
            busy_q    <= 1'b0;
            cause_q   <= '0;
            mask_q    <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            int_q     <= int_d;
            entry_q   <= entry_d;
            busy_q    <= busy_d;
            cause_q   <= cause_d;
            mask_q    <= mask_d;
            pending_q <= pending_d;
        end
    end

    assign INT_o        = int_q;
    assign entryPoint_o = entry_q;
    assign busy_o       = busy_q;
    assign cause_o      = cause_q;
    assign mask_o       = mask_q;
    assign pending_o    = pending_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed vector table, hand-written corner sequences, then random traffic against a model.
// Honours IRQ_EDGE_EN the same way the design does.
module tb_int_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  irq;
    logic        maskWe;
    logic [3:0]  maskWd;
    logic        iret;
    logic [31:0] vecBase;
    logic        intOut;
    logic [31:0] entryPoint;
    logic        busy;
    logic [1:0]  cause;
    logic [3:0]  mask;
    logic [3:0]  pending;

    int checks = 0;
    int errors = 0;

    int_ctrl #(
        .NIRQ       (4),
        .VEC_STRIDE (32'h10),
        .BOOT_ADDR  (32'h28)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .irq_i        (irq),
        .mask_we_i    (maskWe),
        .mask_wd_i    (maskWd),
        .iret_i       (iret),
        .vec_base_i   (vecBase),
        .INT_o        (intOut),
        .entryPoint_o (entryPoint),
        .busy_o       (busy),
        .cause_o      (cause),
        .mask_o       (mask),
        .pending_o    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  irq;
        logic        we;
        logic [3:0]  wd;
        logic        iret;
        logic        eInt;
        logic [31:0] eEntry;
        logic        eBusy;
        logic [1:0]  eCause;
        logic [3:0]  pendEdge;
        logic [3:0]  pendLevel;
        logic [3:0]  eMask;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model state: "boot due", "last strobe was a dispatch", and the visible outputs.
    logic        mBootDue;
    logic        mDispLast;
    logic        mInt;
    logic [31:0] mEntry;
    logic        mBusy;
    logic [1:0]  mCause;
    logic [3:0]  mMask;
    logic [3:0]  mPend;
    logic [3:0]  mPrev;

    function automatic vec_t mk(logic [3:0] i, logic we, logic [3:0] wd, logic rt,
                                logic eI, logic [31:0] eE, logic eB, logic [1:0] eC,
                                logic [3:0] pE, logic [3:0] pL, logic [3:0] eM);
        vec_t v;
        v.irq = i; v.we = we; v.wd = wd; v.iret = rt;
        v.eInt = eI; v.eEntry = eE; v.eBusy = eB; v.eCause = eC;
        v.pendEdge = pE; v.pendLevel = pL; v.eMask = eM;
        return v;
    endfunction

    function automatic int lowestSet(logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic applyStimulus(input logic r, input logic [3:0] i, input logic we,
                                 input logic [3:0] wd, input logic rt, input logic [31:0] vb);
        rst = r; irq = i; maskWe = we; maskWd = wd; iret = rt; vecBase = vb;
        @(posedge clk);
        #1;
    endtask

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input logic eI, input logic [31:0] eE,
                               input logic eB, input logic [1:0] eC, input logic [3:0] eP,
                               input logic [3:0] eM);
        checkField({tag, ".INT"}, 32'(intOut), 32'(eI));
        checkField({tag, ".entryPoint"}, entryPoint, eE);
        checkField({tag, ".busy"}, 32'(busy), 32'(eB));
        checkField({tag, ".cause"}, 32'(cause), 32'(eC));
        checkField({tag, ".pending"}, 32'(pending), 32'(eP));
        checkField({tag, ".mask"}, 32'(mask), 32'(eM));
    endtask

    // Advances the model by one clock edge using the inputs about to be applied.
    task automatic modelStep(input logic r, input logic [3:0] i, input logic we,
                             input logic [3:0] wd, input logic rt, input logic [31:0] vb);
        logic       free;
        int         idx;
        logic       disp;
        logic [3:0] clr;
        if (r) begin
            mBootDue = 1'b1; mDispLast = 1'b0; mInt = 1'b0; mEntry = 32'h28;
            mBusy = 1'b0; mCause = 2'd0; mMask = 4'h0; mPend = 4'h0; mPrev = 4'h0;
            return;
        end
        free = !mBootDue && !mBusy && !mInt;
        idx  = lowestSet(mPend & mMask);
        disp = free && (idx >= 0);
        clr  = disp ? (4'b0001 << idx) : 4'b0000;
        if (mInt && mDispLast) mBusy = 1'b1;
        else if (mBusy && rt) mBusy = 1'b0;
        if (mBootDue) mEntry = 32'h28;
        if (disp) begin
            mEntry = vb + 32'(idx * 16);
            mCause = 2'(idx);
        end
`ifdef IRQ_EDGE_EN
        mPend = (mPend & ~clr) | (i & ~mPrev);
`else
        mPend = i;
`endif
        if (we) mMask = wd;
        mInt      = mBootDue || disp;
        mDispLast = disp;
        mBootDue  = 1'b0;
        mPrev     = i;
    endtask

    initial begin
        logic [3:0] expPend;
        rst = 1'b1; irq = '0; maskWe = 1'b0; maskWd = '0; iret = 1'b0; vecBase = 32'h100;

        // Reset for two cycles, then the boot redirect.
        applyStimulus(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 32'h100);
        applyStimulus(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 32'h100);
        checkOutput("reset", 1'b0, 32'h28, 1'b0, 2'd0, 4'h0, 4'h0);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h100);
        checkOutput("boot", 1'b1, 32'h28, 1'b0, 2'd0, 4'h0, 4'h0);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h100);
        checkOutput("bootEnd", 1'b0, 32'h28, 1'b0, 2'd0, 4'h0, 4'h0);

        // Directed table: single dispatch, two-line priority, masked pending, iret outside SERVICE.
        tbl.push_back(mk(4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 32'h28,  1'b0, 2'd0, 4'h0, 4'h0, 4'hF));
        tbl.push_back(mk(4'h4, 1'b0, 4'h0, 1'b0, 1'b0, 32'h28,  1'b0, 2'd0, 4'h4, 4'h4, 4'hF));
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 32'h120, 1'b0, 2'd2, 4'h0, 4'h0, 4'hF));
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h120, 1'b1, 2'd2, 4'h0, 4'h0, 4'hF));
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h120, 1'b1, 2'd2, 4'h0, 4'h0, 4'hF));
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 32'h120, 1'b0, 2'd2, 4'h0, 4'h0, 4'hF));
        tbl.push_back(mk(4'hA, 1'b0, 4'h0, 1'b0, 1'b0, 32'h120, 1'b0, 2'd2, 4'hA, 4'hA, 4'hF));
        tbl.push_back(mk(4'hA, 1'b0, 4'h0, 1'b0, 1'b1, 32'h110, 1'b0, 2'd1, 4'h8, 4'hA, 4'hF));
        tbl.push_back(mk(4'h8, 1'b0, 4'h0, 1'b0, 1'b0, 32'h110, 1'b1, 2'd1, 4'h8, 4'h8, 4'hF));
        tbl.push_back(mk(4'h8, 1'b0, 4'h0, 1'b0, 1'b0, 32'h110, 1'b1, 2'd1, 4'h8, 4'h8, 4'hF));
        tbl.push_back(mk(4'h8, 1'b0, 4'h0, 1'b1, 1'b0, 32'h110, 1'b0, 2'd1, 4'h8, 4'h8, 4'hF));
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 32'h130, 1'b0, 2'd3, 4'h0, 4'h0, 4'hF));
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h130, 1'b1, 2'd3, 4'h0, 4'h0, 4'hF));
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 32'h130, 1'b0, 2'd3, 4'h0, 4'h0, 4'hF));
        tbl.push_back(mk(4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 32'h130, 1'b0, 2'd3, 4'h0, 4'h0, 4'h0));
        for (int k = 0; k < 10; k++) begin
            tbl.push_back(mk(4'h1, 1'b0, 4'h0, 1'b0, 1'b0, 32'h130, 1'b0, 2'd3, 4'h1, 4'h1, 4'h0));
        end
        tbl.push_back(mk(4'h1, 1'b1, 4'h1, 1'b0, 1'b0, 32'h130, 1'b0, 2'd3, 4'h1, 4'h1, 4'h1));
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 32'h100, 1'b0, 2'd0, 4'h0, 4'h0, 4'h1));
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h100, 1'b1, 2'd0, 4'h0, 4'h0, 4'h1));
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 32'h100, 1'b0, 2'd0, 4'h0, 4'h0, 4'h1));
        tbl.push_back(mk(4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 32'h100, 1'b0, 2'd0, 4'h0, 4'h0, 4'h1));

        foreach (tbl[k]) begin
            applyStimulus(1'b0, tbl[k].irq, tbl[k].we, tbl[k].wd, tbl[k].iret, 32'h100);
`ifdef IRQ_EDGE_EN
            expPend = tbl[k].pendEdge;
`else
            expPend = tbl[k].pendLevel;
`endif
            checkOutput($sformatf("vec%0d", k), tbl[k].eInt, tbl[k].eEntry, tbl[k].eBusy,
                        tbl[k].eCause, expPend, tbl[k].eMask);
        end

        // Reset while a handler is in service with line 3 pending.
        applyStimulus(1'b0, 4'h1, 1'b1, 4'hF, 1'b0, 32'h100);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h100);
        checkField("rstSeq.INT", 32'(intOut), 32'h1);
        applyStimulus(1'b0, 4'h8, 1'b0, 4'h0, 1'b0, 32'h100);
        applyStimulus(1'b0, 4'h8, 1'b0, 4'h0, 1'b0, 32'h100);
        checkField("rstSeq.busy", 32'(busy), 32'h1);
        checkField("rstSeq.pending", 32'(pending), 32'h8);
        applyStimulus(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 32'h100);
        checkOutput("rstBusy", 1'b0, 32'h28, 1'b0, 2'd0, 4'h0, 4'h0);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h100);
        checkOutput("reboot", 1'b1, 32'h28, 1'b0, 2'd0, 4'h0, 4'h0);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h100);
        checkField("rebootEnd.INT", 32'(intOut), 32'h0);

`ifdef IRQ_EDGE_EN
        // Rising edge on the very bit being dispatched: the bit stays latched and fires again.
        applyStimulus(1'b0, 4'h1, 1'b0, 4'h0, 1'b0, 32'h100);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h100);
        applyStimulus(1'b0, 4'h0, 1'b1, 4'h1, 1'b0, 32'h100);
        checkField("setWins.oldMask", 32'(intOut), 32'h0);
        applyStimulus(1'b0, 4'h1, 1'b0, 4'h0, 1'b0, 32'h100);
        checkField("setWins.INT", 32'(intOut), 32'h1);
        checkField("setWins.pending", 32'(pending), 32'h1);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h100);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 32'h100);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h100);
        checkField("setWins.redispatch", 32'(intOut), 32'h1);
        checkField("setWins.entry", entryPoint, 32'h100);
`else
        // Line 1 held high across iret is dispatched again one cycle after returning.
        applyStimulus(1'b0, 4'h2, 1'b1, 4'hF, 1'b0, 32'h100);
        applyStimulus(1'b0, 4'h2, 1'b0, 4'h0, 1'b0, 32'h100);
        checkField("levelHold.INT", 32'(intOut), 32'h1);
        checkField("levelHold.entry", entryPoint, 32'h110);
        applyStimulus(1'b0, 4'h2, 1'b0, 4'h0, 1'b0, 32'h100);
        checkField("levelHold.INTlow", 32'(intOut), 32'h0);
        applyStimulus(1'b0, 4'h2, 1'b0, 4'h0, 1'b1, 32'h100);
        checkField("levelHold.busyDrop", 32'(busy), 32'h0);
        checkField("levelHold.noB2B", 32'(intOut), 32'h0);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h100);
        checkField("levelHold.reINT", 32'(intOut), 32'h1);
        checkField("levelHold.reEntry", entryPoint, 32'h110);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 32'h100);
        checkField("levelHold.reINTlow", 32'(intOut), 32'h0);
`endif

        // Random traffic against the model, starting from a reset.
        modelStep(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);
        applyStimulus(1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 32'h0);
        checkOutput("randRst", mInt, mEntry, mBusy, mCause, mPend, mMask);
        for (int n = 0; n < 3000; n++) begin
            logic        rR, rWe, rIret;
            logic [3:0]  rIrq, rWd;
            logic [31:0] rVb;
            rR    = ($urandom_range(0, 249) == 0);
            rIrq  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : irq;
            rWe   = ($urandom_range(0, 11) == 0);
            rWd   = 4'($urandom_range(0, 15));
            rIret = ($urandom_range(0, 3) == 0);
            rVb   = $urandom;
            modelStep(rR, rIrq, rWe, rWd, rIret, rVb);
            applyStimulus(rR, rIrq, rWe, rWd, rIret, rVb);
            checkOutput("rand", mInt, mEntry, mBusy, mCause, mPend, mMask);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
